// File: rtl/multichannel_dds_core.sv
// rtl/multichannel_dds_core.sv - multi-channel DDS with double-buffered config and 3-stage output pipeline
// Per-channel accumulator feeds phase/index, raw sample and attenuation registers.
module multichannel_dds_core #(
  parameter int CHANNELS  = 2,
  parameter int PHASE_W   = 32,
  parameter int LUT_W     = 10,
  parameter int DATA_W    = 8,
  parameter     SINE_INIT = "sine_lut.mem",
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       phase_sync,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [2:0]                 cfg_addr,
  input  logic [PHASE_W-1:0]         cfg_data,
  output logic [CHANNELS*DATA_W-1:0] wave_o,
  output logic                       wave_valid
);

  localparam int ROM_N = 1 << LUT_W;
  localparam int TOP_W = (LUT_W > DATA_W + 1) ? LUT_W : DATA_W + 1;
  localparam logic [3:0] SHIFT_MAX = 4'(DATA_W - 1);
  localparam logic signed [DATA_W:0] MID_S = {2'b01, {(DATA_W-1){1'b0}}};

  // Sine table is generated at elaboration (offset-binary, full scale); SINE_INIT names the equivalent image.
  function automatic logic [DATA_W-1:0] sine_entry(input int idx);
    longint half, j, u, den, mid, amp, mag;
    half = longint'(1) << (LUT_W - 1);
    j    = longint'(idx) % half;
    u    = j * (half - j);
    den  = 5 * half * half - 4 * u;
    mid  = longint'(1) << (DATA_W - 1);
    amp  = (longint'(idx) < half) ? mid - 1 : mid;
    mag  = (amp * 16 * u + den / 2) / den;
    return (longint'(idx) < half) ? DATA_W'(mid + mag) : DATA_W'(mid - mag);
  endfunction

  logic [DATA_W-1:0] sine_rom [ROM_N];
  for (genvar i = 0; i < ROM_N; i++) begin : g_rom
    assign sine_rom[i] = sine_entry(i);
  end

  logic [PHASE_W-1:0] ftw_sh   [CHANNELS];
  logic [PHASE_W-1:0] off_sh   [CHANNELS];
  logic [1:0]         mode_sh  [CHANNELS];
  logic [3:0]         shift_sh [CHANNELS];
  logic [PHASE_W-1:0] ftw_act  [CHANNELS];
  logic [PHASE_W-1:0] off_act  [CHANNELS];
  logic [1:0]         mode_act [CHANNELS];
  logic [3:0]         shift_act[CHANNELS];

  logic [PHASE_W-1:0] acc      [CHANNELS];
  logic [PHASE_W-1:0] phase    [CHANNELS];
  logic [TOP_W-1:0]   ph1      [CHANNELS];
  logic [1:0]         mode1    [CHANNELS];
  logic [3:0]         shift1   [CHANNELS];
  logic [DATA_W-1:0]  raw2     [CHANNELS];
  logic [3:0]         shift2   [CHANNELS];
  logic [DATA_W-1:0]  atten    [CHANNELS];
  logic [DATA_W-1:0]  out3     [CHANNELS];
  logic signed [DATA_W:0] diff  [CHANNELS];
  logic signed [DATA_W:0] scaled[CHANNELS];
  logic signed [DATA_W:0] sum   [CHANNELS];
  logic v1, v2, v3;

  logic       cfg_fire;
  logic       shadow_wr;
  logic       commit;
  logic [3:0] shift_clamped;

  assign cfg_fire      = cfg_valid && cfg_ready;
  assign shadow_wr     = cfg_fire && !cfg_addr[2];
  assign commit        = cfg_fire && (cfg_addr == 3'd7);
  assign shift_clamped = (int'(cfg_data[3:0]) >= DATA_W) ? SHIFT_MAX : cfg_data[3:0];

  // Channel match inside the loop makes out-of-range cfg_ch a silent no-op.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        ftw_sh[c]    <= '0;
        off_sh[c]    <= '0;
        mode_sh[c]   <= '0;
        shift_sh[c]  <= '0;
        ftw_act[c]   <= '0;
        off_act[c]   <= '0;
        mode_act[c]  <= '0;
        shift_act[c] <= '0;
      end
    end else begin
      cfg_ready <= !commit;
      for (int c = 0; c < CHANNELS; c++) begin
        if (shadow_wr && cfg_ch == CH_W'(c)) begin
          case (cfg_addr[1:0])
            2'd0:    ftw_sh[c]   <= cfg_data;
            2'd1:    off_sh[c]   <= cfg_data;
            2'd2:    mode_sh[c]  <= cfg_data[1:0];
            default: shift_sh[c] <= shift_clamped;
          endcase
        end
        if (commit) begin
          ftw_act[c]   <= ftw_sh[c];
          off_act[c]   <= off_sh[c];
          mode_act[c]  <= mode_sh[c];
          shift_act[c] <= shift_sh[c];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (phase_sync)
          acc[c] <= '0;
        else if (en)
          acc[c] <= acc[c] + ftw_act[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      phase[c]  = acc[c] + off_act[c];
      diff[c]   = $signed({1'b0, raw2[c]}) - MID_S;
      scaled[c] = diff[c] >>> shift2[c];
      sum[c]    = MID_S + scaled[c];
      atten[c]  = sum[c][DATA_W-1:0];
    end
  end

  // Pipeline advances every cycle; only the valid flag tracks en.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ph1[c]    <= '0;
        mode1[c]  <= '0;
        shift1[c] <= '0;
        raw2[c]   <= '0;
        shift2[c] <= '0;
        out3[c]   <= '0;
      end
    end else begin
      v1 <= en;
      v2 <= v1;
      v3 <= v2;
      for (int c = 0; c < CHANNELS; c++) begin
        ph1[c]    <= phase[c][PHASE_W-1 -: TOP_W];
        mode1[c]  <= mode_act[c];
        shift1[c] <= shift_act[c];
        case (mode1[c])
          2'd0:    raw2[c] <= sine_rom[ph1[c][TOP_W-1 -: LUT_W]];
          2'd1:    raw2[c] <= {DATA_W{!ph1[c][TOP_W-1]}};
          2'd2:    raw2[c] <= ph1[c][TOP_W-1 -: DATA_W];
          default: raw2[c] <= ph1[c][TOP_W-1] ? ~ph1[c][TOP_W-2 -: DATA_W]
                                              :  ph1[c][TOP_W-2 -: DATA_W];
        endcase
        shift2[c] <= shift1[c];
        out3[c]   <= atten[c];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign wave_o[c*DATA_W +: DATA_W] = out3[c];
  end
  assign wave_valid = v3;

endmodule
